// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds three stage resets, then releases bit0, bit1, bit2
// at programmed intervals. Runs automatically after rst and on each software request.
module rst_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_req_i,
    output logic [2:0] stage_rst_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] seq_cnt_o
);

    typedef enum logic [1:0] {IDLE, ASSERT, REL0, REL1} state_t;

    // Counter value seen on the edge that completes a phase.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ASSERT;
            cnt         <= '0;
            stage_rst_o <= 3'b111;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            seq_cnt_o   <= '0;
        end else begin
            done_o <= 1'b0;
            if (sw_req_i) begin
                // A request from any state (re)starts the hold phase from zero.
                state       <= ASSERT;
                cnt         <= '0;
                stage_rst_o <= 3'b111;
                busy_o      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        stage_rst_o <= 3'b000;
                        busy_o      <= 1'b0;
                    end
                    ASSERT: begin
                        if (cnt == HOLD_LAST) begin
                            state       <= REL0;
                            cnt         <= '0;
                            stage_rst_o <= 3'b110;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    REL0: begin
                        if (cnt == GAP_LAST) begin
                            state       <= REL1;
                            cnt         <= '0;
                            stage_rst_o <= 3'b100;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    REL1: begin
                        if (cnt == GAP_LAST) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            stage_rst_o <= 3'b000;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            seq_cnt_o   <= seq_cnt_o + 8'd1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        cnt         <= '0;
                        stage_rst_o <= 3'b000;
                        busy_o      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
